// File: rtl/jk_ff_ctrl_pkg.sv
// Shared types and helpers for the arbitrated JK flip-flop command controller.
package jk_ff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Command encoding is {S, R}.
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_INV  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_ff_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_req_o
);

    int unsigned idx;

    always_comb begin
        winner_o  = ptr_i;
        any_req_o = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req_o && req_i[IDW'(idx)]) begin
                winner_o  = IDW'(idx);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_ff_cmd_arbiter.sv
// Shares one JK state bit among NREQ requesters: grant, apply as J/K, then acknowledge.
module jk_ff_cmd_arbiter
    import jk_ff_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] S,
    input  logic [NREQ-1:0] R,
    output logic [NREQ-1:0] ACK,
    output logic            ERR,
    output logic            J,
    output logic            K,
    output logic            Q,
    output logic [IDW-1:0]  GRANT_ID,
    output logic            BUSY
);

    state_e          state_q, state_d;
    logic            q_q, q_d;
    logic            j_q, j_d;
    logic            k_q, k_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            inv_q, inv_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic [IDW-1:0]  winner;
    logic            any_req;
    logic [1:0]      cmd;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i     (REQ),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Next-state and registered-output logic; J/K/ACK/ERR default low every cycle.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        err_d   = 1'b0;
        ack_d   = '0;
        busy_d  = busy_q;
        inv_d   = inv_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cmd     = {S[winner], R[winner]};

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    inv_d   = (cmd == CMD_INV);
                    j_d     = (cmd == CMD_SET);
                    k_d     = (cmd == CMD_RST);
                    busy_d  = 1'b1;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                q_d     = jk_next(q_q, j_q, k_q);
                ack_d   = NREQ'(1) << grant_q;
                err_d   = inv_q;
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            q_q     <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            inv_q   <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            j_q     <= j_d;
            k_q     <= k_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            inv_q   <= inv_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ACK      = ack_q;
    assign ERR      = err_q;
    assign J        = j_q;
    assign K        = k_q;
    assign Q        = q_q;
    assign GRANT_ID = grant_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_jk_ff_cmd_arbiter.sv
// Randomized scoreboard bench for jk_ff_cmd_arbiter with a transaction-level reference model.
module tb_jk_ff_cmd_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] S;
    logic [NREQ-1:0] R;
    logic [NREQ-1:0] ACK;
    logic            ERR;
    logic            J;
    logic            K;
    logic            Q;
    logic [IDW-1:0]  GRANT_ID;
    logic            BUSY;

    jk_ff_cmd_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .S        (S),
        .R        (R),
        .ACK      (ACK),
        .ERR      (ERR),
        .J        (J),
        .K        (K),
        .Q        (Q),
        .GRANT_ID (GRANT_ID),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned     apply_cyc;
        logic            j;
        logic            k;
        logic            err;
        logic            q;
        logic            abort;
        logic [NREQ-1:0] ack;
        logic [IDW-1:0]  gid;
    } exp_t;

    exp_t        expq[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        mon_en = 1'b0;

    // Reference model state: what each requester wants, pointer, flip-flop value.
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] cs;
    logic [NREQ-1:0] cr;
    int              gnt;
    int unsigned     m_ptr;
    logic            m_q;
    int unsigned     next_sample;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: J/K expected only in the apply cycle, ACK/ERR only in the completion cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (expq.size() > 0 && expq[0].apply_cyc == cyc) begin
                chk("apply_j", 32'(J), 32'(expq[0].j));
                chk("apply_k", 32'(K), 32'(expq[0].k));
                chk("apply_busy", 32'(BUSY), 32'd1);
                chk("apply_gid", 32'(GRANT_ID), 32'(expq[0].gid));
            end else begin
                chk("idle_jk", 32'({J, K}), 32'd0);
            end
            if (expq.size() > 0 && expq[0].apply_cyc + 1 == cyc) begin
                exp_t it;
                it = expq.pop_front();
                if (it.abort) begin
                    chk("abort_ack", 32'(ACK), 32'd0);
                    chk("abort_q", 32'(Q), 32'd0);
                    chk("abort_busy", 32'(BUSY), 32'd0);
                    chk("abort_gid", 32'(GRANT_ID), 32'd0);
                end else begin
                    chk("done_ack", 32'(ACK), 32'(it.ack));
                    chk("done_err", 32'(ERR), 32'(it.err));
                    chk("done_q", 32'(Q), 32'(it.q));
                    chk("done_gid", 32'(GRANT_ID), 32'(it.gid));
                    chk("done_busy", 32'(BUSY), 32'd1);
                end
            end else begin
                chk("no_ack", 32'({ACK, ERR}), 32'd0);
            end
        end
    end

    // Non-sampling cycle: hold pending requests, scramble everything the DUT must ignore.
    task automatic tick_busy();
        REQ = pend;
        S   = (cs & pend) | (NREQ'($urandom) & ~pend);
        R   = (cr & pend) | (NREQ'($urandom) & ~pend);
        if (gnt >= 0) begin
            REQ[gnt] = 1'($urandom);
            S[gnt]   = 1'($urandom);
            R[gnt]   = 1'($urandom);
        end
    endtask

    // Sampling cycle: post new commands, predict the round-robin winner and its outcome.
    task automatic issue(input logic [NREQ-1:0] add, input logic [NREQ-1:0] as,
                         input logic [NREQ-1:0] ar, input logic abort);
        int   w;
        exp_t it;
        if (gnt >= 0) pend[gnt] = 1'b0;
        gnt = -1;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (add[i] && !pend[i]) begin
                pend[i] = 1'b1;
                cs[i]   = as[i];
                cr[i]   = ar[i];
            end
        end
        REQ = pend;
        S   = (cs & pend) | (NREQ'($urandom) & ~pend);
        R   = (cr & pend) | (NREQ'($urandom) & ~pend);
        w = -1;
        for (int i = 0; i < int'(NREQ); i++) begin
            int idx;
            idx = int'((m_ptr + 32'(i)) % NREQ);
            if (w < 0 && pend[idx]) w = idx;
        end
        if (w < 0) begin
            next_sample = cyc + 1;
        end else begin
            it.apply_cyc = cyc + 1;
            it.j     = cs[w] & ~cr[w];
            it.k     = cr[w] & ~cs[w];
            it.err   = cs[w] & cr[w];
            it.abort = abort;
            it.ack   = '0;
            it.ack[w] = 1'b1;
            it.gid   = IDW'(w);
            if (!abort) begin
                if (cs[w] && !cr[w]) m_q = 1'b1;
                if (cr[w] && !cs[w]) m_q = 1'b0;
                m_ptr = (32'(w) + 1) % NREQ;
            end
            it.q = m_q;
            expq.push_back(it);
            gnt = w;
            next_sample = cyc + 3;
        end
    endtask

    // Entered and left positioned at an undriven falling edge.
    task automatic wait_issue(input logic [NREQ-1:0] add, input logic [NREQ-1:0] as,
                              input logic [NREQ-1:0] ar, input logic abort);
        while (cyc != next_sample) begin
            tick_busy();
            @(negedge CLK);
        end
        issue(add, as, ar, abort);
        @(negedge CLK);
        if (abort) begin
            tick_busy();
            RST = 1'b1;
            @(negedge CLK);
            RST   = 1'b0;
            pend  = '0;
            gnt   = -1;
            m_ptr = 0;
            m_q   = 1'b0;
            next_sample = cyc;
        end
    endtask

    initial begin
        RST   = 1'b1;
        REQ   = '0;
        S     = '0;
        R     = '0;
        pend  = '0;
        cs    = '0;
        cr    = '0;
        gnt   = -1;
        m_ptr = 0;
        m_q   = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_jk", 32'({J, K}), 32'd0);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_gid", 32'(GRANT_ID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        mon_en = 1'b1;
        next_sample = cyc;

        wait_issue(4'b0001, 4'b0001, 4'b0000, 1'b0);   // set
        wait_issue(4'b0100, 4'b0000, 4'b0100, 1'b0);   // reset from Q=1
        wait_issue(4'b0001, 4'b0001, 4'b0000, 1'b0);   // set again
        wait_issue(4'b0010, 4'b0010, 4'b0010, 1'b0);   // invalid, Q stays 1
        wait_issue(4'b1000, 4'b0000, 4'b0000, 1'b0);   // hold, S/R scrambled after grant
        for (int n = 0; n < 5; n++) begin
            wait_issue(4'b1111, 4'b1111, 4'b0000, 1'b0);
        end
        repeat (3) wait_issue(4'b0000, 4'b0000, 4'b0000, 1'b0);
        wait_issue(4'b0010, 4'b0010, 4'b0000, 1'b0);   // pointer moves to 2
        wait_issue(4'b0100, 4'b0100, 4'b0000, 1'b1);   // aborted by reset
        wait_issue(4'b0110, 4'b0110, 4'b0000, 1'b0);   // requester 1 must win

        for (int n = 0; n < 400; n++) begin
            wait_issue(NREQ'($urandom_range(0, 15)), NREQ'($urandom), NREQ'($urandom), 1'b0);
        end

        for (int n = 0; n < 10 && expq.size() > 0; n++) begin
            tick_busy();
            @(negedge CLK);
        end
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jk_ff_cmd_arbiter.md
Name: jk_ff_cmd_arbiter

Overview:
Shared-flip-flop command controller. NREQ requesters each post an SR-style command: set, reset or hold. A round-robin arbiter grants one command at a time and converts it to JK drive (J=S, K=R). The command is applied to an internal JK state bit Q, and completion is returned on a per-requester ACK. The invalid SR pattern 11 is rejected rather than allowed to toggle Q. The block sits between control logic and the converted-flip-flop datapath: it sequences and shares one flip-flop among several masters.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of GRANT_ID; must equal clog2(NREQ)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
REQ  input  NREQ  per-requester command valid
S  input  NREQ  per-requester set bit
R  input  NREQ  per-requester reset bit
ACK  output  NREQ  one-cycle completion pulse, one-hot or zero
ERR  output  1  high with ACK when the completed command was S=R=1
J  output  1  registered JK drive, J input
K  output  1  registered JK drive, K input
Q  output  1  flip-flop state
GRANT_ID  output  IDW  index of the current or last granted requester
BUSY  output  1  high in APPLY and DONE states

Behaviour:
- Interface: one clock (CLK). Reset is RST: synchronous, active-high.
- Reset values: state IDLE, Q=0, J=0, K=0, ACK=0, ERR=0, GRANT_ID=0, BUSY=0, RR pointer=0.
- FSM states: IDLE, APPLY, DONE. Each transaction takes exactly 3 cycles.
- IDLE:
  - REQ is sampled only in this state.
  - If REQ != 0, the winner is the first asserted bit searching upward from the pointer, wrapping at NREQ-1 to 0.
  - On the transition edge, latch GRANT_ID=winner and latch cmd={S[winner],R[winner]}.
  - Next state is APPLY. If REQ=0, stay in IDLE.
- APPLY: J/K are registered outputs, valid for this cycle only.
  - cmd 00: J=0, K=0 (hold)
  - cmd 10: J=1, K=0 (set)
  - cmd 01: J=0, K=1 (reset)
  - cmd 11: J=0, K=0, invalid flag set
  - At the edge ending APPLY, Q updates per the JK equation: Q+ = J&~Q | ~K&Q.
  - Next state is DONE.
- DONE:
  - ACK[GRANT_ID]=1 and ERR=invalid flag.
  - J=K=0. Q already holds the new value.
  - Pointer becomes (GRANT_ID+1) mod NREQ.
  - Next state is IDLE.
- Outside DONE, ACK=0 and ERR=0. Outside APPLY, J=K=0.
- Requester protocol:
  - Hold REQ high until ACK is seen.
  - S/R changes after the grant edge are ignored.
  - REQ still high in the first IDLE cycle after ACK starts a new transaction, subject to round-robin order.
- Simultaneous requests: strict round-robin. A continuously requesting master waits at most NREQ-1 transactions.
- REQ deasserted mid-transaction: the transaction still completes and ACK still pulses.
- Invalid command never changes Q.
- RST mid-transaction: abort, no ACK, all outputs return to reset values on the next edge.
- GRANT_ID holds its value through IDLE until the next grant.

Decomposition:
- Package jk_ff_ctrl_pkg:
  - state enum {IDLE, APPLY, DONE}
  - command constants CMD_HOLD=2'b00, CMD_RST=2'b01, CMD_SET=2'b10, CMD_INV=2'b11
- Sub-module rr_arbiter (NREQ, IDW): combinational.
  - Inputs: req vector, pointer.
  - Outputs: winner index and any_req.
- The top level holds the FSM, latches, Q and the pointer.

Test Plan:
- Reset then single set: RST high 2 cycles, then REQ=0001, S=0001, R=0000 → J=1 in the cycle after grant; ACK=0001 two cycles after grant; Q=1; ERR=0.
- Reset after set: from Q=1, requester 2 sends S=0, R=1 → K=1 in APPLY; ACK=0100; Q=0.
- Invalid command: requester 1 sends S=R=1 with Q=1 → J=K=0; ACK=0010 with ERR=1; Q stays 1.
- Round-robin fairness: REQ=1111 held, S=1111, R=0 → ACK sequence 0001, 0010, 0100, 1000, 0001; one ACK every 3 cycles; GRANT_ID 0,1,2,3,0.
- Hold command and late S/R change: requester 3 sends S=R=0, then drives S=1 during APPLY → Q unchanged; ACK=1000.
- Reset mid-op: assert RST during APPLY of a set → no ACK; next cycle Q=0, BUSY=0, pointer=0. A following REQ=0110 grants requester 1 first.
